// File: rtl/myocontrol_spi_master.sv
// SPI master: frames of num_words words to one of NUM_SS slaves, all four SPI modes,
// programmable SCK divider, ready/valid transmit side and strobed receive side.
module myocontrol_spi_master #(
  parameter int NUM_SS     = 8,
  parameter int DATA_WIDTH = 16,
  parameter int SEL_W      = 3
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [SEL_W-1:0]      slave_sel,
  input  logic [7:0]            num_words,
  input  logic                  cpol,
  input  logic                  cpha,
  input  logic [7:0]            div,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic                  sck,
  output logic                  mosi,
  input  logic                  miso,
  output logic [NUM_SS-1:0]     ss_n
);

  localparam int EW = $clog2(2 * DATA_WIDTH);
  localparam logic [EW-1:0]    LastEdge = EW'(2 * DATA_WIDTH - 1);
  localparam logic [SEL_W:0]   NumSs    = (SEL_W + 1)'(NUM_SS);

  typedef enum logic [2:0] {StIdle, StLoad, StAssert, StShift, StHold} state_e;

  state_e                state_q;
  logic [SEL_W-1:0]      sel_q;
  logic [7:0]            words_q;
  logic                  cpol_q;
  logic                  cpha_q;
  logic [7:0]            div_q;
  logic [7:0]            cnt_q;
  logic [EW-1:0]         edge_q;
  logic [DATA_WIDTH-1:0] tx_sh_q;
  logic [DATA_WIDTH-1:0] rx_sh_q;
  logic                  first_q;

  logic bad_req;
  logic tick;
  logic sample_edge;

  assign bad_req     = (num_words == 8'd0) || ({1'b0, slave_sel} >= NumSs);
  assign tick        = (cnt_q == div_q);
  // Even edges are leading; cpha=0 samples on leading, cpha=1 on trailing.
  assign sample_edge = ~edge_q[0] ^ cpha_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      sel_q    <= '0;
      words_q  <= '0;
      cpol_q   <= 1'b0;
      cpha_q   <= 1'b0;
      div_q    <= '0;
      cnt_q    <= '0;
      edge_q   <= '0;
      tx_sh_q  <= '0;
      rx_sh_q  <= '0;
      first_q  <= 1'b0;
      tx_ready <= 1'b0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      sck      <= 1'b0;
      mosi     <= 1'b0;
      ss_n     <= '1;
    end else begin
      rx_valid <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            if (bad_req) begin
              err <= 1'b1;
            end else begin
              sel_q    <= slave_sel;
              words_q  <= num_words;
              cpol_q   <= cpol;
              cpha_q   <= cpha;
              div_q    <= div;
              sck      <= cpol;
              busy     <= 1'b1;
              tx_ready <= 1'b1;
              first_q  <= 1'b1;
              state_q  <= StLoad;
            end
          end
        end
        StLoad: begin
          if (tx_valid && tx_ready) begin
            tx_ready <= 1'b0;
            tx_sh_q  <= tx_data;
            mosi     <= tx_data[DATA_WIDTH-1];
            cnt_q    <= '0;
            edge_q   <= '0;
            first_q  <= 1'b0;
            if (first_q) begin
              ss_n    <= ~(NUM_SS'(1) << sel_q);
              state_q <= StAssert;
            end else begin
              state_q <= StShift;
            end
          end
        end
        StAssert: begin
          if (tick) begin
            cnt_q   <= '0;
            state_q <= StShift;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        StShift: begin
          if (!tick) begin
            cnt_q <= cnt_q + 8'd1;
          end else begin
            cnt_q  <= '0;
            sck    <= ~sck;
            edge_q <= edge_q + 1'b1;
            if (sample_edge) begin
              rx_sh_q <= {rx_sh_q[DATA_WIDTH-2:0], miso};
            end else if (edge_q != '0 && edge_q != LastEdge) begin
              // MSB is already on mosi from the load, so the first shift edge is skipped.
              tx_sh_q <= tx_sh_q << 1;
              mosi    <= tx_sh_q[DATA_WIDTH-2];
            end
            if (edge_q == LastEdge) begin
              rx_data  <= cpha_q ? {rx_sh_q[DATA_WIDTH-2:0], miso} : rx_sh_q;
              rx_valid <= 1'b1;
              words_q  <= words_q - 8'd1;
              if (words_q == 8'd1) begin
                state_q <= StHold;
              end else begin
                tx_ready <= 1'b1;
                state_q  <= StLoad;
              end
            end
          end
        end
        StHold: begin
          sck <= cpol_q;
          if (tick) begin
            ss_n    <= '1;
            done    <= 1'b1;
            busy    <= 1'b0;
            state_q <= StIdle;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_myocontrol_spi_master.sv
// Randomised and directed bench for myocontrol_spi_master: an SPI slave model plus
// scoreboard queues for received words and captured mosi words.
`timescale 1ns/1ps
module tb_myocontrol_spi_master;

  localparam int DW = 16;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic          start;
  logic [2:0]    slave_sel;
  logic [7:0]    num_words;
  logic          cpol;
  logic          cpha;
  logic [7:0]    div;
  logic [DW-1:0] tx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic [DW-1:0] rx_data;
  logic          rx_valid;
  logic          busy;
  logic          done;
  logic          err;
  logic          sck;
  logic          mosi;
  logic          miso;
  logic [7:0]    ss_n;

  logic          start2;
  logic [2:0]    sel2;
  logic [7:0]    nw2;
  logic          tx_ready2;
  logic [DW-1:0] rx_data2;
  logic          rx_valid2;
  logic          busy2;
  logic          done2;
  logic          err2;
  logic          sck2;
  logic          mosi2;
  logic [5:0]    ss_n2;

  myocontrol_spi_master #(.NUM_SS(8), .DATA_WIDTH(DW), .SEL_W(3)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .slave_sel(slave_sel),
    .num_words(num_words), .cpol(cpol), .cpha(cpha), .div(div),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy), .done(done), .err(err),
    .sck(sck), .mosi(mosi), .miso(miso), .ss_n(ss_n)
  );

  myocontrol_spi_master #(.NUM_SS(6), .DATA_WIDTH(DW), .SEL_W(3)) dut6 (
    .clk(clk), .reset_n(reset_n), .start(start2), .slave_sel(sel2),
    .num_words(nw2), .cpol(cpol), .cpha(cpha), .div(div),
    .tx_data(tx_data), .tx_valid(1'b0), .tx_ready(tx_ready2),
    .rx_data(rx_data2), .rx_valid(rx_valid2), .busy(busy2), .done(done2), .err(err2),
    .sck(sck2), .mosi(mosi2), .miso(1'b0), .ss_n(ss_n2)
  );

  int total = 0;
  int passed = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got 0x%0h required 0x%0h", name, got, exp);
  endtask

  task automatic note_fail(input string name);
    total++;
    $display("FAIL %s: got no matching event, required one", name);
  endtask

  // Scoreboards and frame-level observations
  logic [DW-1:0] exp_rx_q[$];
  logic [DW-1:0] exp_mosi_q[$];
  logic [DW-1:0] slave_q[$];
  logic [DW-1:0] frame_tx[$];
  logic [DW-1:0] frame_sl[$];

  int cyc = 0;
  int rxv_cnt, done_cnt, err_cnt, err2_cnt, ss2_bad;
  int sck_edge_cnt, sck_rise_cnt, last_rise, period_bad, exp_period, ss_bad;
  logic ss_low_seen, busy2_seen, prev_sck;
  logic [7:0] exp_ss;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rx_valid) begin
      rxv_cnt++;
      if (exp_rx_q.size() == 0) note_fail("rx_unexpected");
      else check("rx_data", 32'(rx_data), 32'(exp_rx_q.pop_front()));
    end
    if (done) done_cnt++;
    if (err) err_cnt++;
    if (err2) err2_cnt++;
    if (busy2) busy2_seen = 1'b1;
    if (ss_n2 != 6'h3F) ss2_bad++;
    if (sck != prev_sck) begin
      sck_edge_cnt++;
      if (sck) begin
        if (sck_rise_cnt > 0 && (cyc - last_rise) != exp_period) period_bad++;
        sck_rise_cnt++;
        last_rise = cyc;
      end
    end
    prev_sck = sck;
    if (busy) begin
      if (ss_n == exp_ss) ss_low_seen = 1'b1;
      else if (ss_n != 8'hFF || ss_low_seen) ss_bad++;
    end
  end

  // SPI slave model: presents its words on miso and captures mosi per SPI mode rules.
  logic          loopback;
  logic          s_miso;
  logic          m_cpol, m_cpha;
  logic [DW-1:0] s_word, s_in;
  int            s_out_idx, s_edges, s_words_left;
  logic          ss_idle;

  assign ss_idle = &ss_n;
  assign miso = loopback ? mosi : s_miso;

  task automatic slave_load();
    s_word = (slave_q.size() != 0) ? slave_q.pop_front() : '0;
    s_edges = 0;
    s_out_idx = 0;
    if (!m_cpha) begin
      s_miso = s_word[DW-1];
      s_out_idx = 1;
    end
  endtask

  always @(negedge ss_idle) if (reset_n) slave_load();

  always @(sck) begin
    if (!ss_idle && reset_n) begin
      if ((sck != m_cpol) ^ m_cpha) s_in = {s_in[DW-2:0], mosi};
      else if (s_out_idx < DW) begin
        s_miso = s_word[DW-1-s_out_idx];
        s_out_idx++;
      end
      s_edges++;
      if (s_edges == 2 * DW) begin
        if (exp_mosi_q.size() == 0) note_fail("mosi_unexpected");
        else check("mosi_word", 32'(s_in), 32'(exp_mosi_q.pop_front()));
        s_words_left--;
        if (s_words_left > 0) slave_load();
      end
    end
  end

  task automatic check_reset_vals(input string tag);
    check({tag, "_ss_n"}, 32'(ss_n), 32'hFF);
    check({tag, "_sck"}, 32'(sck), 32'h0);
    check({tag, "_mosi"}, 32'(mosi), 32'h0);
    check({tag, "_tx_ready"}, 32'(tx_ready), 32'h0);
    check({tag, "_busy"}, 32'(busy), 32'h0);
    check({tag, "_flags"}, {29'd0, rx_valid, done, err}, 32'h0);
    check({tag, "_rx_data"}, 32'(rx_data), 32'h0);
  endtask

  task automatic wait_tx_ready();
    int t = 0;
    while (tx_ready !== 1'b1 && t < 4000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 4000) note_fail("tx_ready_timeout");
  endtask

  task automatic prep_frame(input logic [2:0] sel, input logic c_pol, input logic c_pha,
                            input logic [7:0] dv, input int n, input bit lb);
    m_cpol = c_pol;
    m_cpha = c_pha;
    loopback = lb;
    s_words_left = n;
    exp_ss = ~(8'h01 << sel);
    exp_period = 2 * (int'(dv) + 1);
    ss_low_seen = 1'b0;
    ss_bad = 0;
    rxv_cnt = 0;
    done_cnt = 0;
    err_cnt = 0;
    slave_q = frame_sl;
    start = 1'b1;
    slave_sel = sel;
    num_words = 8'(n);
    cpol = c_pol;
    cpha = c_pha;
    div = dv;
    @(negedge clk);
    start = 1'b0;
    // Configuration inputs change mid-frame; the latched copy must be used.
    slave_sel = 3'($urandom);
    num_words = 8'($urandom);
    cpol = ~c_pol;
    cpha = ~c_pha;
    div = 8'($urandom);
    sck_edge_cnt = 0;
    sck_rise_cnt = 0;
    period_bad = 0;
    prev_sck = sck;
  endtask

  task automatic run_frame(input logic [2:0] sel, input logic c_pol, input logic c_pha,
                           input logic [7:0] dv, input int n, input int gap_before,
                           input int gap_len, input bit lb);
    int t;
    int gap_bad;
    logic [DW-1:0] last_exp;
    for (int i = 0; i < n; i++) begin
      exp_mosi_q.push_back(frame_tx[i]);
      exp_rx_q.push_back(lb ? frame_tx[i] : frame_sl[i]);
    end
    last_exp = lb ? frame_tx[n-1] : frame_sl[n-1];
    @(negedge clk);
    prep_frame(sel, c_pol, c_pha, dv, n, lb);
    check("busy_after_start", 32'(busy), 32'h1);
    for (int w = 0; w < n; w++) begin
      if (w == gap_before) begin
        wait_tx_ready();
        gap_bad = 0;
        repeat (gap_len) begin
          @(negedge clk);
          if (!(tx_ready === 1'b1 && sck === c_pol && ss_n === exp_ss)) gap_bad++;
        end
        check("underflow_stall", 32'(gap_bad), 32'h0);
      end
      tx_data = frame_tx[w];
      tx_valid = 1'b1;
      wait_tx_ready();
      @(negedge clk);
      tx_valid = 1'b0;
      tx_data = DW'($urandom);
      check("tx_ready_drop", 32'(tx_ready), 32'h0);
      if (w == 1) begin
        start = 1'b1;
        slave_sel = 3'd0;
        num_words = 8'($urandom_range(0, 3));
        @(negedge clk);
        start = 1'b0;
      end
    end
    t = 0;
    while (done !== 1'b1 && t < 8000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 8000) note_fail("done_timeout");
    @(negedge clk);
    check("ss_n_after", 32'(ss_n), 32'hFF);
    check("busy_after", 32'(busy), 32'h0);
    check("done_count", 32'(done_cnt), 32'h1);
    check("err_count", 32'(err_cnt), 32'h0);
    check("rx_valid_count", 32'(rxv_cnt), 32'(n));
    check("sck_idle", 32'(sck), 32'(c_pol));
    check("ss_n_frame", 32'(ss_bad), 32'h0);
    check("ss_low_seen", 32'(ss_low_seen), 32'h1);
    check("sck_edges", 32'(sck_edge_cnt), 32'(2 * DW * n));
    if (n == 1) check("sck_period", 32'(period_bad), 32'h0);
    check("rx_queue_empty", 32'(exp_rx_q.size()), 32'h0);
    check("mosi_queue_empty", 32'(exp_mosi_q.size()), 32'h0);
    repeat (5) @(negedge clk);
    check("rx_data_hold", 32'(rx_data), 32'(last_exp));
  endtask

  initial begin
    int n;
    int t;
    reset_n = 1'b1;
    start = 1'b0; slave_sel = '0; num_words = '0; cpol = 1'b0; cpha = 1'b0; div = '0;
    tx_data = '0; tx_valid = 1'b0; start2 = 1'b0; sel2 = '0; nw2 = '0;
    loopback = 1'b1; s_miso = 1'b0; m_cpol = 1'b0; m_cpha = 1'b0; prev_sck = 1'b0;
    #1 reset_n = 1'b0;
    #2 check_reset_vals("reset");
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    cpol = 1'b1;
    repeat (4) @(negedge clk);
    check("sck_before_first_start", 32'(sck), 32'h0);
    cpol = 1'b0;

    // Single word, mode 0, loopback
    frame_tx = '{16'hA5C3};
    frame_sl = '{16'h0000};
    run_frame(3'd5, 1'b0, 1'b0, 8'd1, 1, -1, 0, 1'b1);
    check("mode0_rises", 32'(sck_rise_cnt), 32'd16);

    // Mode 3, three words with slave responses
    frame_tx = '{16'h0001, 16'h8000, 16'hFFFF};
    frame_sl = '{16'h1234, 16'h5678, 16'h9ABC};
    run_frame(3'd2, 1'b1, 1'b1, 8'd2, 3, -1, 0, 1'b0);

    // Underflow before word 2
    frame_tx = '{16'hC0DE, 16'h1F2E};
    frame_sl = '{16'h7E81, 16'h0FF0};
    run_frame(3'd6, 1'b0, 1'b1, 8'd0, 2, 1, 50, 1'b0);

    // Bad requests on the 6-slave instance
    @(negedge clk);
    err2_cnt = 0; busy2_seen = 1'b0; ss2_bad = 0;
    start2 = 1'b1; sel2 = 3'd2; nw2 = 8'd0;
    @(negedge clk);
    start2 = 1'b0;
    @(negedge clk);
    start2 = 1'b1; sel2 = 3'd7; nw2 = 8'd4;
    @(negedge clk);
    start2 = 1'b0;
    repeat (5) @(negedge clk);
    check("err_pulses", 32'(err2_cnt), 32'd2);
    check("err_busy", 32'(busy2_seen), 32'h0);
    check("err_ss_n", 32'(ss2_bad), 32'h0);

    // Reset after the eighth bit of a word
    frame_tx = '{16'h3C96};
    frame_sl = '{16'h0000};
    @(negedge clk);
    prep_frame(3'd3, 1'b0, 1'b0, 8'd1, 1, 1'b1);
    tx_data = 16'h3C96;
    tx_valid = 1'b1;
    wait_tx_ready();
    @(negedge clk);
    tx_valid = 1'b0;
    t = 0;
    while (sck_edge_cnt < 16 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 2000) note_fail("reset_edge_timeout");
    #1 reset_n = 1'b0;
    #1 check_reset_vals("midreset");
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    check("midreset_no_done", 32'(done_cnt), 32'h0);
    check("midreset_idle", 32'(busy), 32'h0);
    exp_rx_q.delete();
    exp_mosi_q.delete();
    s_words_left = 0;
    frame_tx = '{16'h5A0F, 16'hE187};
    frame_sl = '{16'h2468, 16'hBDF1};
    run_frame(3'd0, 1'b0, 1'b0, 8'd1, 2, -1, 0, 1'b0);

    // Randomised frames
    for (int f = 0; f < 5; f++) begin
      n = $urandom_range(1, 4);
      frame_tx.delete();
      frame_sl.delete();
      for (int i = 0; i < n; i++) begin
        frame_tx.push_back(DW'($urandom));
        frame_sl.push_back(DW'($urandom));
      end
      run_frame(3'($urandom_range(0, 7)), 1'($urandom), 1'($urandom),
                8'($urandom_range(0, 3)), n, -1, 0, 1'($urandom));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
